// File: rtl/mb_rx_flit_buffer.sv
// Flit buffer behind the mainband receiver: captures valid-only flit strobes into a
// DEPTH-entry FIFO and presents a valid/ready stream. MB_RX_FLIT_BUF_ALMOST_FULL_EN adds almost_full_o.
module mb_rx_flit_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned FLIT_BYTES = 64
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_THRESH  = DEPTH - 1
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flit_valid_i,
  input  logic [7:0]               flit_data_i [FLIT_BYTES],
  output logic                     flit_valid_o,
  input  logic                     flit_ready_i,
  output logic [7:0]               flit_data_o [FLIT_BYTES],
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_count_o,
  input  logic                     ovf_clr_i
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
  ,
  output logic                     almost_full_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem [DEPTH][FLIT_BYTES];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n, occ_n;
  logic          full, push, pop, drop, bypass;
  logic          overflow_n;
  logic [15:0]   drop_count_n;

  // Next-state computation for pointers, occupancy and overflow bookkeeping
  always_comb begin
    full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop          = flit_valid_o && flit_ready_i;
    push         = flit_valid_i && (!full || pop);
    drop         = flit_valid_i && full && !pop;
    wr_ptr_n     = wr_ptr + PW'(push);
    rd_ptr_n     = rd_ptr + PW'(pop);
    occ_n        = wr_ptr_n - rd_ptr_n;
    // The new flit becomes the head only when it lands in the slot rd_ptr_n points at
    bypass       = push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0]);
    overflow_n   = overflow_o;
    drop_count_n = drop_count_o;
    if (ovf_clr_i) begin
      overflow_n   = 1'b0;
      drop_count_n = 16'd0;
    end
    if (drop) begin
      overflow_n = 1'b1;
      if (drop_count_n != 16'hFFFF) drop_count_n = drop_count_n + 16'd1;
    end
  end

  // Control state with asynchronous discard of all queued flits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy_o  <= '0;
      flit_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
      drop_count_o <= 16'd0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      occupancy_o  <= occ_n;
      flit_valid_o <= (occ_n != '0);
      overflow_o   <= overflow_n;
      drop_count_o <= drop_count_n;
    end
  end

  // Storage and registered head flit; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= flit_data_i;
    if (bypass) flit_data_o <= flit_data_i;
    else        flit_data_o <= mem[rd_ptr_n[AW-1:0]];
  end

`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) almost_full_o <= 1'b0;
    else        almost_full_o <= (occ_n >= PW'(AF_THRESH));
  end
`endif

endmodule

// File: tb/tb_mb_rx_flit_buffer.sv
// Self-checking bench for mb_rx_flit_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_mb_rx_flit_buffer;

  localparam int DEPTH = 4;
  localparam int FB    = 64;
  localparam int AF    = DEPTH - 1;

  typedef logic [7:0] flit_t [FB];

  logic        clk = 1'b0;
  logic        reset;
  logic        flit_valid_i;
  logic [7:0]  flit_data_i [FB];
  logic        flit_valid_o;
  logic        flit_ready_i;
  logic [7:0]  flit_data_o [FB];
  logic [2:0]  occupancy_o;
  logic        overflow_o;
  logic [15:0] drop_count_o;
  logic        ovf_clr_i;
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
  logic        almost_full_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  flit_t mq[$];
  bit    m_ovf;
  int    m_cnt;

  mb_rx_flit_buffer #(.DEPTH(DEPTH), .FLIT_BYTES(FB)) dut (
    .clk          (clk),
    .reset        (reset),
    .flit_valid_i (flit_valid_i),
    .flit_data_i  (flit_data_i),
    .flit_valid_o (flit_valid_o),
    .flit_ready_i (flit_ready_i),
    .flit_data_o  (flit_data_o),
    .occupancy_o  (occupancy_o),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o),
    .ovf_clr_i    (ovf_clr_i)
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
    ,
    .almost_full_o(almost_full_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] pk(input flit_t f);
    logic [511:0] r;
    for (int i = 0; i < FB; i++) r[i*8 +: 8] = f[i];
    return r;
  endfunction

  function automatic flit_t mk_str(input string s);
    flit_t f;
    for (int i = 0; i < FB; i++) f[i] = (i < s.len()) ? 8'(s[i]) : 8'h20;
    return f;
  endfunction

  function automatic flit_t mk_rand();
    flit_t f;
    for (int i = 0; i < FB; i++) f[i] = 8'($urandom);
    return f;
  endfunction

  task automatic drive(input bit v, input flit_t d, input bit r, input bit c);
    flit_valid_i = v;
    flit_data_i  = d;
    flit_ready_i = r;
    ovf_clr_i    = c;
  endtask

  // Advance one clock edge and apply the specified FIFO rules to the model
  task automatic tick();
    bit    pop, full, push, drop, clr;
    flit_t nd;
    pop  = (mq.size() != 0) && flit_ready_i;
    full = (mq.size() == DEPTH);
    push = flit_valid_i && (!full || pop);
    drop = flit_valid_i && full && !pop;
    clr  = ovf_clr_i;
    nd   = flit_data_i;
    @(posedge clk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(nd);
    if (clr) begin m_ovf = 0; m_cnt = 0; end
    if (drop) begin m_ovf = 1; if (m_cnt < 65535) m_cnt++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, mk_rand(), 0, 0);
    mq.delete(); m_ovf = 0; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (flit_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", flit_valid_o); else n_pass++;
    n_checks++; if (occupancy_o !== 3'd0) $display("FAIL reset_occ got=%0d exp=0", occupancy_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow_o); else n_pass++;
    n_checks++; if (drop_count_o !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", drop_count_o); else n_pass++;
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
    n_checks++; if (almost_full_o !== 1'b0) $display("FAIL reset_af got=%b exp=0", almost_full_o); else n_pass++;
`endif
  endtask

  task automatic test_single_flit();
    flit_t h;
    h = mk_str("Hello world, this is Flit 0.");
    drive(1, h, 0, 0); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (flit_valid_o !== 1'b1) $display("FAIL single_valid got=%b exp=1", flit_valid_o); else n_pass++;
    n_checks++; if (occupancy_o !== 3'd1) $display("FAIL single_occ got=%0d exp=1", occupancy_o); else n_pass++;
    n_checks++; if (pk(flit_data_o) !== pk(h)) $display("FAIL single_data got=%h exp=%h", pk(flit_data_o), pk(h)); else n_pass++;
    tick();
    n_checks++; if (pk(flit_data_o) !== pk(h)) $display("FAIL single_hold got=%h exp=%h", pk(flit_data_o), pk(h)); else n_pass++;
    drive(0, mk_rand(), 1, 0); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (occupancy_o !== 3'd0) $display("FAIL single_pop_occ got=%0d exp=0", occupancy_o); else n_pass++;
    n_checks++; if (flit_valid_o !== 1'b0) $display("FAIL single_pop_valid got=%b exp=0", flit_valid_o); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    flit_t f [6];
    do_reset();
    for (int i = 0; i < 6; i++) begin f[i] = mk_rand(); drive(1, f[i], 0, 0); tick(); end
    drive(0, mk_rand(), 0, 0);
    n_checks++; if (occupancy_o !== 3'd4) $display("FAIL fill_occ got=%0d exp=4", occupancy_o); else n_pass++;
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL fill_ovf got=%b exp=1", overflow_o); else n_pass++;
    n_checks++; if (drop_count_o !== 16'd2) $display("FAIL fill_cnt got=%0d exp=2", drop_count_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pk(flit_data_o) !== pk(f[i])) $display("FAIL drain_%0d got=%h exp=%h", i, pk(flit_data_o), pk(f[i])); else n_pass++;
      drive(0, mk_rand(), 1, 0); tick();
    end
    n_checks++; if (flit_valid_o !== 1'b0) $display("FAIL drain_empty got=%b exp=0", flit_valid_o); else n_pass++;
    drive(0, mk_rand(), 1, 1); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (overflow_o !== 1'b0 || drop_count_o !== 16'd0)
      $display("FAIL clear ovf=%b cnt=%0d exp ovf=0 cnt=0", overflow_o, drop_count_o); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    flit_t f [5];
    do_reset();
    for (int i = 0; i < 4; i++) begin f[i] = mk_rand(); drive(1, f[i], 0, 0); tick(); end
    f[4] = mk_rand();
    drive(1, f[4], 1, 0); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (drop_count_o !== 16'd0) $display("FAIL fullpp_cnt got=%0d exp=0", drop_count_o); else n_pass++;
    n_checks++; if (occupancy_o !== 3'd4) $display("FAIL fullpp_occ got=%0d exp=4", occupancy_o); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (pk(flit_data_o) !== pk(f[i])) $display("FAIL fullpp_order_%0d got=%h exp=%h", i, pk(flit_data_o), pk(f[i])); else n_pass++;
      drive(0, mk_rand(), 1, 0); tick();
    end
    drive(0, mk_rand(), 0, 0);
  endtask

  task automatic test_clear_collision();
    do_reset();
    for (int i = 0; i < 9; i++) begin drive(1, mk_rand(), 0, 0); tick(); end
    n_checks++; if (drop_count_o !== 16'd5) $display("FAIL coll_pre_cnt got=%0d exp=5", drop_count_o); else n_pass++;
    drive(1, mk_rand(), 0, 1); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (overflow_o !== 1'b1) $display("FAIL coll_ovf got=%b exp=1", overflow_o); else n_pass++;
    n_checks++; if (drop_count_o !== 16'd1) $display("FAIL coll_cnt got=%0d exp=1", drop_count_o); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    flit_t f;
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, mk_rand(), 0, 0); tick(); end
    drive(0, mk_rand(), 0, 0);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (flit_valid_o !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", flit_valid_o); else n_pass++;
    n_checks++; if (occupancy_o !== 3'd0) $display("FAIL midrst_occ got=%0d exp=0", occupancy_o); else n_pass++;
    reset = 1'b1;
    mq.delete(); m_ovf = 0; m_cnt = 0;
    f = mk_rand();
    drive(1, f, 0, 0); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (flit_valid_o !== 1'b1 || pk(flit_data_o) !== pk(f))
      $display("FAIL midrst_push valid=%b got=%h exp=%h", flit_valid_o, pk(flit_data_o), pk(f)); else n_pass++;
  endtask

`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
  task automatic test_almost_full();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, mk_rand(), 0, 0); tick();
      n_checks++; if (almost_full_o !== (i == 2)) $display("FAIL af_push_%0d got=%b exp=%b", i, almost_full_o, (i == 2)); else n_pass++;
    end
    drive(0, mk_rand(), 1, 0); tick(); drive(0, mk_rand(), 0, 0);
    n_checks++; if (almost_full_o !== 1'b0) $display("FAIL af_pop got=%b exp=0", almost_full_o); else n_pass++;
  endtask
`endif

  task automatic test_random();
    int errs;
    int vp, rp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      vp = (c / 100) % 2 ? 80 : 50;
      rp = (c / 150) % 2 ? 70 : 25;
      drive(($urandom_range(99) < vp), mk_rand(), ($urandom_range(99) < rp), ($urandom_range(29) == 0));
      tick();
      errs = 0;
      if (flit_valid_o !== (mq.size() != 0)) errs++;
      if (occupancy_o !== 3'(mq.size())) errs++;
      if (mq.size() != 0 && pk(flit_data_o) !== pk(mq[0])) errs++;
      if (overflow_o !== m_ovf || drop_count_o !== 16'(m_cnt)) errs++;
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
      if (almost_full_o !== (mq.size() >= AF)) errs++;
`endif
      n_checks++;
      if (errs != 0)
        $display("FAIL random_c%0d valid=%b occ=%0d ovf=%b cnt=%0d exp occ=%0d ovf=%b cnt=%0d",
                 c, flit_valid_o, occupancy_o, overflow_o, drop_count_o, mq.size(), m_ovf, m_cnt);
      else n_pass++;
    end
    drive(0, mk_rand(), 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, mk_rand(), 0, 0);
    test_reset();
    test_single_flit();
    test_fill_overflow();
    test_full_push_pop();
    test_clear_collision();
    test_reset_midstream();
`ifdef MB_RX_FLIT_BUF_ALMOST_FULL_EN
    test_almost_full();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mb_rx_flit_buffer.md
Name: mb_rx_flit_buffer

Overview:
- Sits directly downstream of the mainband receiver, on the receiver's 100 MHz core clock.
- Captures each reassembled 64-byte flit the receiver presents with a one-cycle valid and queues it in a DEPTH-entry FIFO.
- The receiver cannot be back-pressured, so the block converts its valid-only pulse into a valid/ready stream for the adapter layer.
- Flits that arrive while the FIFO is full are dropped, counted, and flagged with a sticky overflow indication.

Parameters:
- DEPTH, 4, number of flit entries; power of 2, minimum 2.
- FLIT_BYTES, 64, bytes per flit.
- AF_THRESH, DEPTH-1, occupancy at or above which almost_full_o asserts (optional feature only).

Ports:
- clk  input  1  core clock, 100 MHz domain of the mainband receiver.
- reset  input  1  asynchronous, active-low reset.
- flit_valid_i  input  1  one-cycle strobe from the receiver; flit_data_i is valid this cycle.
- flit_data_i  input  8 x FLIT_BYTES  unpacked byte array [7:0] [FLIT_BYTES-1:0]; byte 0 is the first byte on the wire.
- flit_valid_o  output  1  head flit available.
- flit_ready_i  input  1  consumer accepts the head flit when it is high together with flit_valid_o.
- flit_data_o  output  8 x FLIT_BYTES  head flit, same layout as the input.
- occupancy_o  output  $clog2(DEPTH)+1  number of stored flits, 0..DEPTH.
- overflow_o  output  1  sticky; set when a flit is dropped.
- drop_count_o  output  16  saturating count of dropped flits.
- ovf_clr_i  input  1  synchronous clear of overflow_o and drop_count_o.
- almost_full_o  output  1  present only with the optional feature.

Behaviour:
- Reset (reset low, asynchronous): pointers = 0, occupancy_o = 0, flit_valid_o = 0, overflow_o = 0, drop_count_o = 0, almost_full_o = 0. flit_data_o content is don't-care while flit_valid_o = 0. Storage is not required to be reset.
- Pointers: write and read pointers are $clog2(DEPTH)+1 bits and wrap naturally.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - occupancy_o = wr_ptr - rd_ptr, registered.
- Push: on a clk edge with flit_valid_i = 1 and not full, all FLIT_BYTES bytes are written to mem[wr_ptr] and wr_ptr increments.
- Output timing: flit_valid_o = (occupancy != 0); flit_data_o = mem[rd_ptr], read from registered storage.
  - A flit pushed at edge N is visible at the output after edge N (latency 1 cycle), including the case where the FIFO was empty.
- Pop: on a clk edge with flit_valid_o = 1 and flit_ready_i = 1, rd_ptr increments.
  - flit_ready_i while empty is ignored.
  - flit_data_o must remain stable while flit_valid_o = 1 and flit_ready_i = 0.
- Simultaneous push and pop:
  - Both take effect; occupancy is unchanged.
  - When full, the pop frees the slot, so the push is accepted and nothing is dropped.
  - When empty, there is no pop (flit_valid_o = 0), so the push is accepted alone.
- Drop: flit_valid_i = 1 while full with no pop in the same cycle.
  - The flit is discarded and storage is untouched.
  - overflow_o is set to 1.
  - drop_count_o increments, saturating at 16'hFFFF.
- Clear: ovf_clr_i = 1 clears overflow_o and drop_count_o.
  - If a drop occurs in the same cycle, the result is overflow_o = 1 and drop_count_o = 1 (the drop is counted after the clear).
- Reset mid-operation: asserting reset discards all queued flits immediately (asynchronously). flit_valid_o drops without waiting for clk.
- Design assumption: the receiver's valid strobe is one cycle per flit, but back-to-back strobes on consecutive cycles must be handled without loss while space is available.

Optional Feature:
- Macro: MB_RX_FLIT_BUF_ALMOST_FULL_EN.
- Defined:
  - Port almost_full_o exists. It is registered and equals (next occupancy >= AF_THRESH), so it updates on the same edge as occupancy_o.
  - It is intended as a credit-return hint toward the link partner.
  - Reset value is 0.
- Undefined: the port and its logic are absent, and AF_THRESH is unused.

Test Plan:
- Single flit: after reset release, push flit "Hello world, this is Flit 0." (space-padded to 64 bytes) with flit_ready_i = 0 -> one cycle later flit_valid_o = 1, occupancy_o = 1, flit_data_o matches byte-for-byte. Then raise flit_ready_i for one cycle -> occupancy_o = 0, flit_valid_o = 0.
- Fill and overflow (DEPTH = 4): push 6 flits on consecutive cycles with flit_ready_i = 0 -> occupancy_o = 4, overflow_o = 1, drop_count_o = 2. Draining yields flits 0..3 in order.
- Full with simultaneous push and pop: fill to 4, then push and pop in the same cycle -> drop_count_o stays 0, occupancy_o stays 4. Output order is flits 1,2,3,new.
- Clear collision: with overflow_o = 1 and drop_count_o = 5, assert ovf_clr_i in the same cycle as a drop -> overflow_o = 1, drop_count_o = 1.
- Reset mid-stream: with 3 queued flits, pulse reset low between clk edges -> flit_valid_o = 0 and occupancy_o = 0 immediately. The next push appears at the output one cycle later.
- Optional feature with AF_THRESH = 3: push 3 flits -> almost_full_o rises on the edge that makes occupancy 3. One pop -> almost_full_o = 0.
